// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone-style master.
// Optional timeout logic in wb_mst is enabled with WB_MST_TIMEOUT_EN.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mst_state_t;

    localparam int WB_ADDR_W          = 8;
    localparam int WB_DATA_W          = 8;
    localparam int WB_TIMEOUT_DEFAULT = 16;
    localparam int WB_TIMEOUT_CNT_W   = 8;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts strobe cycles without acknowledge; expired flags the cycle the limit is hit.
// Only instantiated by wb_mst when WB_MST_TIMEOUT_EN is defined.
module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int LIMIT = WB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [WB_TIMEOUT_CNT_W-1:0] cnt;

    // expired fires on the edge that would complete the LIMIT-th waiting cycle
    assign expired = en && (cnt == WB_TIMEOUT_CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_mst.sv
// Single-outstanding Wishbone-style master: one bus transaction per command.
// Define WB_MST_TIMEOUT_EN to abort strobes that are not acknowledged in time.
module wb_mst
    import wb_pkg::*;
#(
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              we,
    output logic              stb,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ack
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid holds its payload stable until that edge.

    mst_state_t        state, state_n;
    logic              ready_en;
    logic              stb_n, we_n, rsp_valid_n, rsp_err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n, rsp_rdata_n;
    logic              timed_out;

    // ready_en keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = ready_en && (state == IDLE);

`ifdef WB_MST_TIMEOUT_EN
    logic cnt_clear, cnt_en;

    assign cnt_clear = cmd_valid && cmd_ready;
    assign cnt_en    = (state == REQ) && !ack;

    wb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        stb_n       = stb;
        we_n        = we;
        addr_n      = addr;
        wdata_n     = wdata;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    stb_n   = 1'b1;
                    we_n    = cmd_we;
                    addr_n  = cmd_addr;
                    wdata_n = cmd_wdata;
                    state_n = REQ;
                end
            end
            REQ: begin
                // Dropping stb on the ack edge prevents the slave from seeing a second request
                if (ack) begin
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    rsp_rdata_n = we ? '0 : rdata;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    state_n     = RESP;
                end else if (timed_out) begin
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    rsp_rdata_n = '0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            stb       <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            ready_en  <= 1'b1;
            stb       <= stb_n;
            we        <= we_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_wb_mst.sv
// Directed testbench for wb_mst with a small single-ack slave memory model.
// Expectations adapt to WB_MST_TIMEOUT_EN when it is defined.
module tb_wb_mst;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic       we, stb;
    logic [7:0] addr, wdata, rdata;
    logic       ack, ack_r, ack_inj, ack_hold;

    logic [7:0] mem [256];
    int         txn_cnt;
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    wb_mst #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .we        (we),
        .stb       (stb),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack)
    );

    // Slave model: one-cycle ack pulse, rdata valid in the ack cycle
    assign ack = ack_r | ack_inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r   <= 1'b0;
            rdata   <= 8'h00;
            txn_cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            ack_r <= 1'b0;
            if (stb && !ack_r && !ack_hold) begin
                ack_r   <= 1'b1;
                txn_cnt <= txn_cnt + 1;
                if (we) mem[addr] <= wdata;
                else    rdata     <= mem[addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Presents a command (caller at a negedge) and returns at the negedge after acceptance
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input bit drop);
        int n;
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        exp_q.push_back(exp);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (drop) cmd_valid = 1'b0;
    endtask

    // Waits for a response, checks it against the scoreboard; handshake completes on the next edge
    task automatic collect(input logic exp_err);
        int n;
        logic [7:0] exp;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("rsp_rdata", rsp_rdata, exp);
        check("rsp_err", rsp_err, exp_err);
    endtask

    initial begin
        int base, cnt;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        rsp_ready = 1'b1; ack_inj = 1'b0; ack_hold = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_stb", stb, 0);
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("cmd_ready_pre_edge", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_post_edge", cmd_ready, 1);

        // Write then read back
        issue(1'b1, 8'h3C, 8'hA5, 8'h00, 1'b1);
        check("wr_stb", stb, 1);
        check("wr_we", we, 1);
        check("wr_addr", addr, 8'h3C);
        check("wr_wdata", wdata, 8'hA5);
        collect(1'b0);
        @(negedge clk);
        check("idle_stb", stb, 0);
        issue(1'b0, 8'h3C, 8'h00, 8'hA5, 1'b1);
        check("rd_we", we, 0);
        collect(1'b0);
        @(negedge clk);

        // Back-to-back with cmd_valid held high
        base = txn_cnt;
        issue(1'b1, 8'h01, 8'h11, 8'h00, 1'b0); collect(1'b0);
        issue(1'b1, 8'h02, 8'h22, 8'h00, 1'b0); collect(1'b0);
        issue(1'b0, 8'h01, 8'h00, 8'h11, 1'b0); collect(1'b0);
        issue(1'b0, 8'h02, 8'h00, 8'h22, 1'b1); collect(1'b0);
        @(negedge clk); @(negedge clk);
        check("b2b_txn_count", txn_cnt - base, 4);

        // Response backpressure
        issue(1'b1, 8'h77, 8'h5A, 8'h00, 1'b1); collect(1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 8'h77, 8'h00, 8'h5A, 1'b1);
        cnt = 0;
        while (!rsp_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 8'h5A);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_stb", stb, 0);
            @(negedge clk);
        end
        collect(1'b0);
        @(negedge clk);

        // Reset in the middle of a strobe
        ack_hold = 1'b1;
        issue(1'b0, 8'h3C, 8'h00, 8'h00, 1'b1);
        check("mid_stb_before", stb, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_stb_async", stb, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        ack_hold = 1'b0;
        issue(1'b0, 8'h3C, 8'h00, 8'h00, 1'b1);
        collect(1'b0);
        @(negedge clk);

        // Withheld acknowledge
        issue(1'b1, 8'h3C, 8'hC3, 8'h00, 1'b1); collect(1'b0);
        @(negedge clk);
        ack_hold = 1'b1;
`ifdef WB_MST_TIMEOUT_EN
        issue(1'b0, 8'h3C, 8'h00, 8'h00, 1'b1);
        cnt = 0;
        while (stb && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_stb_cycles", cnt, TMO);
        collect(1'b1);
`else
        issue(1'b0, 8'h3C, 8'h00, 8'hC3, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (stb) cnt++;
            @(negedge clk);
        end
        check("noack_stb_cycles", cnt, 40);
        ack_hold = 1'b0;
        collect(1'b0);
`endif
        ack_hold = 1'b0;
        @(negedge clk);

        // Stray ack while idle
        ack_inj = 1'b1;
        @(negedge clk);
        ack_inj = 1'b0;
        check("late_ack_stb", stb, 0);
        check("late_ack_rsp_valid", rsp_valid, 0);
        check("late_ack_cmd_ready", cmd_ready, 1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_mst.md
Name: wb_mst

Overview:
- Single-outstanding Wishbone-style master; directly upstream of the 8-bit Wishbone slave memory, driving its we/stb/addr/wdata and consuming its rdata/ack.
- Accepts read/write commands from a local requester over a valid/ready command channel.
- Runs one bus transaction per command and returns a response (read data plus error flag) on a valid/ready response channel.

Parameters:
- ADDR_W, 8, bus address width (matches slave).
- DATA_W, 8, bus data width (matches slave).
- TIMEOUT_CYCLES, 16, max cycles stb held without ack before abort (used only with WB_MST_TIMEOUT_EN; legal 2..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  master can accept a command (high only in IDLE).
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data (ignored for reads).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  transaction timed out (always 0 without WB_MST_TIMEOUT_EN).
- we  output  1  bus write enable to slave.
- stb  output  1  bus strobe to slave.
- addr  output  ADDR_W  bus address.
- wdata  output  DATA_W  bus write data.
- rdata  input  DATA_W  bus read data from slave.
- ack  input  1  bus acknowledge (one-cycle pulse from slave).

Behaviour:
- Reset (async, rst_n low):
  - All outputs and registers cleared immediately: stb=0, we=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; state=IDLE.
  - cmd_ready goes high from the first edge after rst_n rises.
  - Reset mid-transaction drops stb immediately; the command is lost and no response is issued.
- All outputs are registered; cmd_ready is decoded from state only.
- IDLE: cmd_ready=1.
  - On cmd_valid at a rising edge, register cmd_we/addr/wdata onto we/addr/wdata, set stb=1, go to REQ.
  - stb is visible the cycle after acceptance.
- REQ: hold stb, we, addr and wdata stable until ack is sampled high.
  - On an edge with ack=1: clear stb and we; capture rsp_rdata = we ? 0 : rdata (slave rdata is valid in the same cycle as ack); set rsp_valid=1, rsp_err=0; go to RESP.
  - Deasserting stb on the ack edge guarantees the slave's next mode check sees stb=0 (no double transaction).
- RESP: hold rsp_valid, rsp_rdata and rsp_err until rsp_ready is sampled high.
  - On handshake, clear rsp_valid and go to IDLE.
  - No new command is accepted in the handshake cycle: minimum 1 cycle of IDLE between transactions.
- ack sampled in IDLE or RESP: ignored, with no state change.
- Latency: command accept -> stb high = 1 cycle; ack edge -> rsp_valid high = same edge (registered, visible next cycle).
  - Against the slave, command accept to rsp_valid is 3..5 cycles depending on the slave's phase.
- addr and wdata keep their last values after a transaction; only stb qualifies them.

Optional Feature:
- Macro: WB_MST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: stb=0, we=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to RESP.
  - If ack and the limit coincide on the same edge, ack wins (normal completion, err=0).
- Not defined: no counter; REQ waits indefinitely; rsp_err is tied 0.

Decomposition:
- Package wb_pkg:
  - mst_state_t enum (IDLE=0, REQ=1, RESP=2).
  - WB_ADDR_W=8, WB_DATA_W=8 constants.
  - Default timeout constant.
- Sub-module wb_timeout_cnt: clear/enable inputs, expired output. Instantiated only under WB_MST_TIMEOUT_EN.

Test Plan:
- Write then read: cmd write addr=0x3C wdata=0xA5 -> one stb pulse train, we=1, rsp_valid with rsp_rdata=0x00, err=0. Then read 0x3C -> rsp_rdata=0xA5.
- Back-to-back: write 0x01->0x11, write 0x02->0x22, read 0x01, read 0x02 with cmd_valid held high -> rdata 0x11, 0x22. Exactly one slave transaction per command.
- Response backpressure: rsp_ready=0 for 5 cycles after a read of a 0x5A location -> rsp_valid/rsp_rdata=0x5A held stable, cmd_ready=0 throughout, stb stays 0.
- Reset mid-op: assert rst_n=0 while stb=1 -> stb=0 asynchronously (before the next edge), rsp_valid=0. After release, read of any address returns 0x00 (slave also reset).
- Timeout (WB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack tied 0) -> stb high exactly 16 cycles, then rsp_err=1, rsp_rdata=0. Late ack pulse in IDLE is ignored.
- Without macro, ack withheld 40 cycles -> stb stays high for 40 cycles, completes with err=0 once ack arrives.
